// File: rtl/clkdiv_pkg.sv
// Shared defaults and channel-state layout for the clkdiv_multi divider.
package clkdiv_pkg;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_DIV_W      = 8;
    localparam int DEF_RESET_HALF = 1;

    typedef struct packed {
        logic [DEF_DIV_W-1:0] act_h;
        logic [DEF_DIV_W-1:0] pend_h;
        logic                 pend;
        logic [DEF_DIV_W-1:0] cnt;
        logic                 out;
    } ch_state_t;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: half-period counter, output toggle, pending reload, tick.
// Tick flop present only when CLKDIV_TICK_EN is defined; otherwise tick is tied to 0.
module clkdiv_channel #(
    parameter int DIV_W      = 8,
    parameter int RESET_HALF = 1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             resync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_half,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    // Same field set as clkdiv_pkg::ch_state_t, sized by this instance's DIV_W.
    typedef struct packed {
        logic [DIV_W-1:0] act_h;
        logic [DIV_W-1:0] pend_h;
        logic             pend;
        logic [DIV_W-1:0] cnt;
        logic             out;
    } chan_st_t;

    chan_st_t st_q, st_d;
    logic     last;

    always_comb begin
        st_d = st_q;
        last = (st_q.cnt == st_q.act_h - DIV_W'(1));
        if (resync) begin
            st_d.cnt = '0;
            st_d.out = 1'b0;
            if (st_q.pend) begin
                st_d.act_h = st_q.pend_h;
                st_d.pend  = 1'b0;
            end
        end else if (st_q.pend && (st_q.act_h == '0 || !en)) begin
            // Nothing is running to wait for, so reload right away.
            st_d.act_h = st_q.pend_h;
            st_d.pend  = 1'b0;
            st_d.cnt   = '0;
            st_d.out   = 1'b0;
        end else if (en && st_q.act_h != '0) begin
            if (last) begin
                st_d.cnt = '0;
                st_d.out = ~st_q.out;
                if (st_q.out && st_q.pend) begin
                    st_d.act_h = st_q.pend_h;
                    st_d.pend  = 1'b0;
                end
            end else begin
                st_d.cnt = st_q.cnt + DIV_W'(1);
            end
        end
        // A write lands after any reload on this edge, so it waits for the next boundary.
        if (wr) begin
            st_d.pend   = 1'b1;
            st_d.pend_h = wr_half;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            st_q.act_h  <= DIV_W'(RESET_HALF);
            st_q.pend_h <= '0;
            st_q.pend   <= 1'b0;
            st_q.cnt    <= '0;
            st_q.out    <= 1'b0;
        end else begin
            st_q <= st_d;
        end
    end

`ifdef CLKDIV_TICK_EN
    logic tick_q;

    // out only rises through a toggle, so a 0->1 transition of the register is the tick.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) tick_q <= 1'b0;
        else        tick_q <= ~st_q.out & st_d.out;
    end

    assign tick = tick_q;
`else
    assign tick = 1'b0;
`endif

    assign clk_out = st_q.out;
    assign pend    = st_q.pend;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel synchronous clock divider: config decode, ready mux, channel array.
// Define CLKDIV_TICK_EN to build the per-channel tick pulse logic.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter  int NUM_CH     = DEF_NUM_CH,
    parameter  int DIV_W      = DEF_DIV_W,
    parameter  int RESET_HALF = DEF_RESET_HALF,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              resync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] wr;

    // Unmapped channel numbers stay ready and match no channel, so the write is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) cfg_ready = ~pend[i];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkdiv_channel #(
            .DIV_W      (DIV_W),
            .RESET_HALF (RESET_HALF)
        ) u_ch (
            .clk_in  (clk_in),
            .rst_n   (rst_n),
            .en      (en[i]),
            .resync  (resync),
            .wr      (wr[i]),
            .wr_half (cfg_half),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pend    (pend[i])
        );
    end

endmodule

// File: doc/clkdiv_multi.md
# clkdiv_multi

Parametrised, fully synchronous multi-channel clock divider, the successor to the fixed ripple divide-by-2^n chain. Each of NUM_CH channels produces a 50%-duty divided clock with a runtime-programmable half-period, per-channel enable, glitch-free reload at period boundaries, and a global phase-align restart. All state lives in the single clk_in domain; outputs are registered, so there are no ripple-clocked flops.

## Interface
- NUM_CH, 4: number of output channels (1..16)
- DIV_W, 8: half-period register width
- RESET_HALF, 1: half-period loaded at reset (1 = divide by 2)
- CH_W, $clog2(NUM_CH) (min 1): channel select width, derived
- clk_in  in  1  sole clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset; deassertion synchronised externally
- en  in  NUM_CH  per-channel run enable
- resync  in  1  synchronous restart of all channels, phase-aligned
- cfg_valid  in  1  configuration write request
- cfg_ready  out  1  write can be accepted for cfg_ch
- cfg_ch  in  CH_W  target channel
- cfg_half  in  DIV_W  new half-period H
- clk_out  out  NUM_CH  divided clocks, registered
- tick  out  NUM_CH  one-cycle pulse coincident with each clk_out rise

## Operation
- Per channel: active half-period act_h, counter cnt (DIV_W), output toggle flop out, pending register pend_h plus pend flag.
- Output period is 2·H clk_in cycles; H=0 stops the channel with clk_out held at 0.
- en=1 and act_h≠0: if cnt==act_h−1, then out toggles and cnt←0; otherwise cnt←cnt+1.
- en=0: cnt and out frozen, no tick.
- Config handshake: cfg_ready = !pend[cfg_ch]. On valid&&ready, pend_h←cfg_half and pend←1. If cfg_ch≥NUM_CH, accept with ready=1 and discard.
- Reload point: at the toggle taking out 1→0, which is the end of a full period, act_h←pend_h, pend←0, cnt←0.
- Reload with the channel stopped (act_h==0) or disabled: applied on the cycle after acceptance, with cnt←0 and out←0.
- Write accepted on the same edge as a reload boundary: it does not affect that boundary and is applied at the next one.
- resync: all channels cnt←0 and out←0, and any pend is applied. It has priority over toggle and en. A write accepted on the resync edge lands in pend after resync.
- tick[i]=1 for exactly the cycle in which clk_out[i] is 1 following a 0→1 toggle.

## Timing
- Reset values: clk_out=0, tick=0, cnt=0, act_h=RESET_HALF, pend=0, cfg_ready=1.
- With en=1 from reset release and H=1: clk_out rises at the first edge and toggles every edge.
- For general H, the first rise comes after H edges.
- Latency from toggle decision to clk_out: 0 extra cycles, since out is the register.
- A stalled cfg_valid must hold cfg_ch and cfg_half stable until ready.
- Changes in H never produce a high or low phase shorter than min(old H, new H).

## Configuration
- CLKDIV_TICK_EN defined: tick generation logic compiled in, with behaviour as above.
- CLKDIV_TICK_EN undefined: tick logic removed, the port is retained, and tick is driven constant 0.

## Structure
- Package clkdiv_pkg holds the default parameter constants (NUM_CH, DIV_W, RESET_HALF) and a channel-state struct typedef {act_h, pend_h, pend, cnt, out}.
- Sub-module clkdiv_channel contains one channel's counter, toggle, reload and tick logic.
- The top holds the config decode, cfg_ready mux, resync fan-out, and generates NUM_CH instances.

## Test plan
- Reset, en=4'b1111, default H=1 → every clk_out has period 2; tick high on each rise; cfg_ready=1.
- Write ch2 H=3 while running at H=1 → exactly one accept; the new period of 6 cycles starts at the next 1→0 edge; the second write is stalled (ready=0) until reload.
- Write ch0 H=0 → after the boundary clk_out[0] stays 0 and tick[0] stays 0; a later write H=5 takes effect the next cycle, with first rise after 5 edges.
- en[1] deasserted mid-high-phase for 7 cycles → clk_out[1] holds 1 and cnt freezes; the phase resumes with the remaining count.
- Channels at H=2,3,4,5 then resync pulse → all clk_out 0 on the next cycle; all rise together when H matches, otherwise on their respective Hth edge.
- NUM_CH=3, cfg_ch=3 write → accepted, no channel changes; rst_n pulsed mid-period → outputs 0 immediately, act_h back to RESET_HALF.
